// File: rtl/conv_y_stream_checker.sv
// Sink/checker for the conv_128_32 y stream: compares accepted samples to expected memory.
// Random backpressure is compiled in with `define CONV_Y_RAND_READY_EN (default: ready held 1).
module conv_y_stream_checker #(
   parameter int          NUMOUTVALS = 970000,
   parameter int          YW         = 21,
   parameter int          AW         = 20,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [YW-1:0] s_data_in_y,
   input  logic                 s_valid_y,
   output logic                 s_ready_y,
   output logic [AW-1:0]        exp_rd_addr,
   input  logic signed [YW-1:0] exp_rd_data,
   output logic [AW:0]          y_count,
   output logic [31:0]          err_count,
   output logic [AW-1:0]        first_err_idx,
   output logic                 first_err_vld,
   output logic                 done,
   output logic                 pass
);

   typedef enum logic [1:0] {
      FETCH,
      ARMED,
      DONE
   } state_t;

   localparam logic [AW:0]   LAST     = (AW+1)'(NUMOUTVALS - 1);
   localparam logic [AW-1:0] ADDR_MAX = AW'(NUMOUTVALS - 1);

   state_t               state;
   state_t               state_nxt;
   logic signed [YW-1:0] exp_reg;
   logic                 rdy_en;
   logic                 cnt_last;
   logic                 hs;
   logic                 mismatch;

`ifdef CONV_Y_RAND_READY_EN
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;

   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign rdy_en = lfsr[0];
`else
   assign rdy_en = 1'b1;
`endif

   assign cnt_last = (y_count == LAST);
   assign hs       = (state == ARMED) && s_valid_y && rdy_en;
   assign mismatch = (s_data_in_y != exp_reg);
   assign pass     = done && (err_count == 32'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // ARMED prefetches the next index so FETCH sees sync-read data in one cycle
   always_comb begin
      state_nxt   = state;
      s_ready_y   = 1'b0;
      exp_rd_addr = ADDR_MAX;
      done        = 1'b0;
      unique case (state)
         FETCH: begin
            exp_rd_addr = y_count[AW-1:0];
            state_nxt   = ARMED;
         end
         ARMED: begin
            s_ready_y   = rdy_en;
            exp_rd_addr = cnt_last ? y_count[AW-1:0]
                                   : y_count[AW-1:0] + AW'(1);
            if (s_valid_y && rdy_en) begin
               state_nxt = cnt_last ? DONE : FETCH;
            end
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_reg       <= '0;
         y_count       <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         first_err_vld <= 1'b0;
      end else begin
         if (state == FETCH) begin
            exp_reg <= exp_rd_data;
         end
         if (hs) begin
            y_count <= y_count + (AW+1)'(1);
            if (mismatch) begin
               if (err_count != 32'hFFFF_FFFF) begin
                  err_count <= err_count + 32'd1;
               end
               if (!first_err_vld) begin
                  first_err_idx <= y_count[AW-1:0];
                  first_err_vld <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_y_stream_checker.sv
// Directed + randomized bench for conv_y_stream_checker against a sample-level model.
module tb_conv_y_stream_checker;

   localparam int N   = 4;
   localparam int AW  = 3;
   localparam int YW  = 21;
   localparam int N8  = 8;
   localparam int AW8 = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic signed [YW-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic [AW-1:0]        rd_addr;
   logic signed [YW-1:0] rd_data;
   logic [AW:0]          y_count;
   logic [31:0]          err_count;
   logic [AW-1:0]        first_idx;
   logic                 first_vld;
   logic                 done;
   logic                 pass;

   logic signed [YW-1:0] mem [2**AW];
   always @(posedge clk) rd_data <= mem[rd_addr];

   conv_y_stream_checker #(
      .NUMOUTVALS(N), .YW(YW), .AW(AW), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .reset(reset),
      .s_data_in_y(s_data), .s_valid_y(s_valid), .s_ready_y(s_ready),
      .exp_rd_addr(rd_addr), .exp_rd_data(rd_data),
      .y_count(y_count), .err_count(err_count),
      .first_err_idx(first_idx), .first_err_vld(first_vld),
      .done(done), .pass(pass)
   );

   logic signed [YW-1:0] data8;
   logic                 ready8;
   logic [AW8-1:0]       addr8;
   logic signed [YW-1:0] rdata8;
   logic [AW8:0]         cnt8;
   logic [31:0]          err8;
   logic [AW8-1:0]       fidx8;
   logic                 fvld8;
   logic                 done8;
   logic                 pass8;
   logic                 valid8;

   always @(posedge clk) rdata8 <= '0;

   conv_y_stream_checker #(
      .NUMOUTVALS(N8), .YW(YW), .AW(AW8), .LFSR_SEED(16'h0)
   ) dut8 (
      .clk(clk), .reset(reset),
      .s_data_in_y(data8), .s_valid_y(valid8), .s_ready_y(ready8),
      .exp_rd_addr(addr8), .exp_rd_data(rdata8),
      .y_count(cnt8), .err_count(err8),
      .first_err_idx(fidx8), .first_err_vld(fvld8),
      .done(done8), .pass(pass8)
   );

   int checks = 0;
   int errors = 0;

   // sample-level model: index of next expected sample, mismatches, first bad index
   logic signed [YW-1:0] send [N];
   int acc, merr, mfirst, sidx;
   bit mvld, prev_hs;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_clear();
      acc = 0; merr = 0; mfirst = 0; mvld = 0; sidx = 0; prev_hs = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic cyc(input logic v, input logic signed [YW-1:0] d);
      logic hs;
      s_valid = v;
      s_data  = d;
      #1;
      hs = v && s_ready;
      if (prev_hs || acc == N) chk("ready_bubble", s_ready, 0);
      @(posedge clk);
      if (hs) begin
         if (d != mem[acc]) begin
            if (!mvld) begin
               mfirst = acc;
               mvld   = 1;
            end
            merr++;
         end
         acc++;
         sidx++;
      end
      prev_hs = hs;
      @(negedge clk);
   endtask

   task automatic outs(input string tag);
      chk({tag, "_ycnt"}, y_count, acc);
      chk({tag, "_err"}, err_count, merr);
      chk({tag, "_fvld"}, first_vld, mvld);
      chk({tag, "_fidx"}, first_idx, mfirst);
      chk({tag, "_done"}, done, acc == N);
      chk({tag, "_pass"}, pass, (acc == N) && (merr == 0));
   endtask

   // mode 0: valid held 1; mode 1: valid 1-in-3 with X data in gaps
   task automatic run(input int mode, input int stop_at);
      int n = 0;
      logic v;
      while (acc < stop_at && n < 300) begin
         v = (mode == 0) ? 1'b1 : (n % 3 == 0);
         cyc(v, v ? send[sidx] : 'x);
         n++;
      end
      chk("cycle_budget", acc < stop_at, 0);
   endtask

   initial begin
      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      valid8  = 1'b1;
      data8   = '0;
      model_clear();
      foreach (mem[i]) mem[i] = '0;
      mem[0] = 5; mem[1] = -3; mem[2] = 100; mem[3] = 0;
      #1;
      outs("rst");
      chk("rst_ready", s_ready, 0);
      chk("rst_addr", rd_addr, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      send[0] = 5; send[1] = -3; send[2] = 100; send[3] = 0;
      run(0, N);
      outs("t1");

      for (int k = 0; k < 10; k++) cyc(1'b1, 7);
      outs("t5");

      send[2] = 99;
      do_reset();
      run(0, N);
      outs("t2");
      chk("t2_fidx_abs", first_idx, 2);

      for (int r = 0; r < 8; r++) begin
         foreach (mem[i]) mem[i] = YW'($urandom);
         for (int i = 0; i < N; i++) begin
            send[i] = mem[i];
            if ((r % 2 == 1) && ($urandom_range(0, 2) == 0)) send[i] = ~mem[i];
         end
         do_reset();
         run(1, N);
         outs("t3");
      end

      for (int i = 0; i < N; i++) send[i] = mem[i];
      send[0] = ~mem[0];
      do_reset();
      run(0, 2);
      outs("t4_pre");
      #2 reset = 1'b1;
      #1;
      chk("t4_ycnt", y_count, 0);
      chk("t4_err", err_count, 0);
      chk("t4_fvld", first_vld, 0);
      chk("t4_fidx", first_idx, 0);
      chk("t4_done", done, 0);
      chk("t4_pass", pass, 0);
      chk("t4_ready", s_ready, 0);
      chk("t4_addr", rd_addr, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      send[0] = mem[0];
      run(0, N);
      outs("t4_rerun");

`ifndef CONV_Y_RAND_READY_EN
      do_reset();
      for (int k = 1; k <= 18; k++) begin
         #1;
         chk("t6_ready", ready8, (k % 2 == 0) && (k <= 16));
         @(posedge clk);
         @(negedge clk);
         chk("t6_cnt", cnt8, (k / 2 > N8) ? N8 : k / 2);
         chk("t6_done", done8, k >= 16);
      end
      chk("t6_err", err8, 0);
      chk("t6_pass", pass8, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
